// File: rtl/muldiv_engine_if.sv
// Handshake bundle between the operand latch (master) and the multiply/divide engine (slave).
interface muldiv_engine_if #(
   parameter int unsigned WIDTH = 32
);
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/muldiv_engine.sv
// Multicycle signed multiply/divide: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, sign fix-up and overflow detection in a final cycle, then a RDY pulse.
module muldiv_engine #(
   parameter int unsigned WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   muldiv_engine_if.slave    mdif
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;      // product high half / partial remainder
   logic [WIDTH-1:0] lo_q, lo_d;      // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
   logic             div_q, div_d;
   logic             neg_q, neg_d;
   logic             bzero_q, bzero_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             exc_q, exc_d;

   logic               start;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod, sprod;
   logic [WIDTH-1:0]   squot;

   // Magnitudes are unsigned, so the most negative operand becomes exactly 2^(WIDTH-1).
   assign a_mag = mdif.data_operandA[WIDTH-1] ? (~mdif.data_operandA + 1'b1) : mdif.data_operandA;
   assign b_mag = mdif.data_operandB[WIDTH-1] ? (~mdif.data_operandB + 1'b1) : mdif.data_operandB;

   assign start = (mdif.ctrl_MULT | mdif.ctrl_DIV) && (state_q == S_IDLE || state_q == S_DONE);

   assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign prod      = {hi_q, lo_q};
   assign sprod     = neg_q ? (~prod + 1'b1) : prod;
   assign squot     = neg_q ? (~lo_q + 1'b1) : lo_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opnd_d  = opnd_q;
      div_d   = div_q;
      neg_d   = neg_q;
      bzero_d = bzero_q;
      res_d   = res_q;
      exc_d   = exc_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = '0;
               hi_d    = '0;
               div_d   = ~mdif.ctrl_MULT;
               neg_d   = mdif.data_operandA[WIDTH-1] ^ mdif.data_operandB[WIDTH-1];
               bzero_d = (mdif.data_operandB == '0);
               opnd_d  = mdif.ctrl_MULT ? a_mag : b_mag;
               lo_d    = mdif.ctrl_MULT ? b_mag : a_mag;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = S_FIN;
            if (!div_q) begin
               hi_d = mul_sum[WIDTH:1];
               lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end else if (div_ge) begin
               hi_d = WIDTH'(div_shift - {1'b0, opnd_q});
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = div_shift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end
         S_FIN: begin
            state_d = S_DONE;
            if (!div_q) begin
               res_d = sprod[WIDTH-1:0];
               exc_d = !((&sprod[2*WIDTH-1:WIDTH-1]) || !(|sprod[2*WIDTH-1:WIDTH-1]));
            end else if (bzero_q) begin
               res_d = '0;
               exc_d = 1'b1;
            end else begin
               // A positive quotient of 2^(WIDTH-1) only arises from MIN / -1.
               res_d = squot;
               exc_d = !neg_q && lo_q[WIDTH-1];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         bzero_q <= 1'b0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         bzero_q <= bzero_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
   end

   assign mdif.data_result    = res_q;
   assign mdif.data_exception = exc_q;
   assign mdif.data_resultRDY = (state_q == S_DONE);
   assign mdif.busy           = (state_q == S_RUN) || (state_q == S_FIN);
endmodule

// File: tb/tb_muldiv_engine.sv
// Directed-vector bench for muldiv_engine: driver pushes expected results, a monitor pops on RDY.
module tb_muldiv_engine;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   muldiv_engine_if #(.WIDTH(32)) bus ();
   muldiv_engine #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .mdif(bus));

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every RDY must match the oldest outstanding expectation, on time.
   always @(negedge clk) begin
      if (!reset && bus.data_resultRDY === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rdy: got RDY=1 expected no RDY (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", 64'(bus.data_result), 64'(e.res));
            chk("exception", 64'(bus.data_exception), 64'(e.exc));
            chk("latency", 64'(cyc), 64'(e.due));
            chk("busy_at_rdy", 64'(bus.busy), 64'd0);
         end
      end
   end

   // Caller is at a negedge; operands are accepted on the following posedge.
   task automatic drive(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic push, input logic [31:0] er, input logic ee);
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      bus.data_operandA = a;
      bus.data_operandB = b;
      @(posedge clk);
      #1;
      if (push) sb.push_back('{res: er, exc: ee, due: cyc + 33});
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
   endtask

   task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee);
      @(negedge clk);
      drive(m, d, a, b, 1'b1, er, ee);
      chk("busy_after_start", 64'(bus.busy), 64'd1);
   endtask

   task automatic drain(input int unsigned limit);
      int unsigned n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rdy_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_idle(input string nm);
      chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
      chk({nm, "_rdy"}, 64'(bus.data_resultRDY), 64'd0);
      chk({nm, "_result"}, 64'(bus.data_result), 64'd0);
      chk({nm, "_exc"}, 64'(bus.data_exception), 64'd0);
   endtask

   initial begin
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;

      issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
      drain(40);
      issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
      drain(40);
      issue(1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
      drain(40);
      issue(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25, 1'b0);
      drain(40);
      issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      drain(40);
      issue(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
      drain(40);
      issue(1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
      drain(40);
      issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      drain(40);
      issue(1'b0, 1'b1, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0);
      drain(40);
      issue(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);
      drain(40);
      // Both requests together: multiply takes precedence.
      issue(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);
      drain(40);

      // Ignored start while busy, then back-to-back start in the RDY cycle.
      issue(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0);
      repeat (9) @(negedge clk);
      drive(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0);
      begin
         int unsigned n = 0;
         @(negedge clk);
         while (bus.data_resultRDY !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("rdy_seen_for_b2b", 64'(bus.data_resultRDY), 64'd1);
      end
      drive(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
      chk("busy_after_b2b_start", 64'(bus.busy), 64'd1);
      drain(40);
      repeat (40) @(negedge clk);

      // Reset mid-operation aborts with no RDY; a start during reset is ignored.
      @(negedge clk);
      drive(1'b1, 1'b0, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0);
      repeat (9) @(negedge clk);
      reset             = 1'b1;
      bus.ctrl_MULT     = 1'b1;
      bus.data_operandA = 32'd5;
      bus.data_operandB = 32'd5;
      @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.ctrl_MULT = 1'b0;
      check_idle("after_reset");
      repeat (40) @(negedge clk);
      chk("idle_after_abort", 64'(bus.busy), 64'd0);
      issue(1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0);
      drain(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
